sc_et_accumulator: RTL and testbench

- Downstream consumer of the early-terminating SC bitstream generator: counts ones on each of NUM_INPUTS stochastic bitstreams and converts them back to WIDTH-bit binary values once the generator signals done.
- Stream lengths are powers of two. Normalisation is a shift by log2(length), so no divider is needed.
- Result is presented through a valid/ready handshake to the binary-side logic or scoreboard.

---
 rtl/sc_et_accumulator.sv | 199 +++++++++++++++++++
 tb/tb_sc_et_accumulator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_et_accumulator.sv
// sc_et_accumulator: turns NUM_INPUTS stochastic bitstreams back into WIDTH-bit binary values.
//
// Counts valid cycles (L) and the ones on each stream. When the source signals done, each
// ones-count is normalised by shifting by floor(log2 L). This is exact when L is a power of two.
// The result is then offered through a valid/ready handshake.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              pulse: clear counters and begin a new capture (wins over everything but rst)
//   xs_valid, Xs       one stochastic bit per stream, counted when xs_valid=1 in ACCUM
//   src_done           source finished; a valid bit in the same cycle is still counted
//   out_valid/ready    result handshake
//   Ys                 recovered values, stream i at [i*WIDTH +: WIDTH]
//   len_log2, len_err  floor(log2 L); error if L is zero, not a power of two, or overflowed
//   busy               high while accumulating
//   prog_valid         only with SC_ET_ACC_PROGRESSIVE_EN defined: one-cycle pulse when Ys holds
//                      a progressive estimate (L reached a power of two >= 2^WIDTH)
module sc_et_accumulator #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  xs_valid,
  input  logic [NUM_INPUTS-1:0]                 Xs,
  input  logic                                  src_done,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_INPUTS*WIDTH-1:0]           Ys,
  output logic [$clog2(NUM_INPUTS*WIDTH+1)-1:0] len_log2,
  output logic                                  len_err,
  output logic                                  busy
`ifdef SC_ET_ACC_PROGRESSIVE_EN
  ,
  output logic                                  prog_valid
`endif
);

  localparam int unsigned NW = NUM_INPUTS * WIDTH;
  localparam int unsigned CW = NW + 1;
  localparam int unsigned LW = $clog2(NW + 1);

  localparam logic [CW-1:0] LenMax = {1'b1, {NW{1'b0}}};
  localparam logic [LW-1:0] WidthL = LW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   len_q, len_d;
  logic [NUM_INPUTS-1:0][CW-1:0]   cnt_q, cnt_d;
  logic                            ovf_q, ovf_d;
  logic [NW-1:0]                   ys_q, ys_d;
  logic [LW-1:0]                   k_q, k_d;
  logic                            err_q, err_d;

  logic [NW-1:0]                   res_ys;
  logic [LW-1:0]                   res_k;
  logic                            res_err;

`ifdef SC_ET_ACC_PROGRESSIVE_EN
  logic                            prog_q, prog_d;
  logic                            bit_counted;
  localparam logic [CW-1:0] ProgMin = {{(CW-1){1'b0}}, 1'b1} << WIDTH;
`endif

  function automatic logic [LW-1:0] flog2(input logic [CW-1:0] v);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CW); i++) begin
      if (v[i]) r = LW'(i);
    end
    return r;
  endfunction

  function automatic logic is_pow2(input logic [CW-1:0] v);
    return (v != '0) && ((v & (v - CW'(1))) == '0);
  endfunction

  // Normalise a ones-count to WIDTH bits: cnt * 2^WIDTH / 2^k, saturating at all-ones.
  function automatic logic [WIDTH-1:0] scale(input logic [CW-1:0] cnt, input logic [LW-1:0] k);
    logic [CW+WIDTH-1:0] wide;
    wide = {{WIDTH{1'b0}}, cnt};
    if (k >= WidthL) wide = wide >> (k - WidthL);
    else             wide = wide << (WidthL - k);
    if (|wide[CW+WIDTH-1:WIDTH]) return '1;
    return wide[WIDTH-1:0];
  endfunction

  // Counter next-state.
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
`ifdef SC_ET_ACC_PROGRESSIVE_EN
    bit_counted = 1'b0;
`endif
    if (start) begin
      cnt_d = '0;
      len_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == StAccum && xs_valid) begin
      if (len_q == LenMax) begin
        // Counters would exceed their range; freeze them and flag the run as invalid.
        ovf_d = 1'b1;
      end else begin
        len_d = len_q + CW'(1);
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
          cnt_d[i] = cnt_q[i] + {{(CW-1){1'b0}}, Xs[i]};
        end
`ifdef SC_ET_ACC_PROGRESSIVE_EN
        bit_counted = 1'b1;
`endif
      end
    end
  end

  // Result from the post-update counts, so a bit arriving with src_done is included.
  always_comb begin
    res_k   = flog2(len_d);
    res_err = (len_d == '0) || !is_pow2(len_d) || ovf_d;
    res_ys  = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      res_ys[i*WIDTH +: WIDTH] = (len_d == '0) ? '0 : scale(cnt_d[i], res_k);
    end
  end

  // State and result-register next-state.
  always_comb begin
    state_d = state_q;
    ys_d    = ys_q;
    k_d     = k_q;
    err_d   = err_q;
`ifdef SC_ET_ACC_PROGRESSIVE_EN
    prog_d  = 1'b0;
`endif
    if (start) begin
      state_d = StAccum;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAccum: begin
`ifdef SC_ET_ACC_PROGRESSIVE_EN
          if (bit_counted && is_pow2(len_d) && (len_d >= ProgMin)) begin
            prog_d = 1'b1;
            ys_d   = res_ys;
          end
`endif
          if (src_done) begin
            state_d = StOut;
            ys_d    = res_ys;
            k_d     = res_k;
            err_d   = res_err;
          end
        end
        StOut: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ys_q    <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
`ifdef SC_ET_ACC_PROGRESSIVE_EN
      prog_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ys_q    <= ys_d;
      k_q     <= k_d;
      err_q   <= err_d;
`ifdef SC_ET_ACC_PROGRESSIVE_EN
      prog_q  <= prog_d;
`endif
    end
  end

  assign out_valid = (state_q == StOut);
  assign busy      = (state_q == StAccum);
  assign Ys        = ys_q;
  assign len_log2  = k_q;
  assign len_err   = err_q;
`ifdef SC_ET_ACC_PROGRESSIVE_EN
  assign prog_valid = prog_q;
`endif

endmodule

// File: tb/tb_sc_et_accumulator.sv
// Scoreboard bench for sc_et_accumulator (WIDTH=4, NUM_INPUTS=2).
module tb_sc_et_accumulator;
  localparam int W    = 4;
  localparam int N    = 2;
  localparam int NW   = N * W;
  localparam int LW   = 4;
  localparam int LMAX = 256;

  logic          clk = 1'b0;
  logic          rst, start, xs_valid, src_done, out_ready;
  logic [N-1:0]  xs;
  logic          out_valid, len_err, busy;
  logic [NW-1:0] ys;
  logic [LW-1:0] len_log2;
`ifdef SC_ET_ACC_PROGRESSIVE_EN
  logic          prog_valid;
`endif

  always #5 clk = ~clk;

  sc_et_accumulator #(.WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .xs_valid  (xs_valid),
    .Xs        (xs),
    .src_done  (src_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Ys        (ys),
    .len_log2  (len_log2),
    .len_err   (len_err),
    .busy      (busy)
`ifdef SC_ET_ACC_PROGRESSIVE_EN
    ,
    .prog_valid(prog_valid)
`endif
  );

  typedef struct packed {
    logic [NW-1:0] ys;
    logic [LW-1:0] k;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t prog_q[$];
  bit   q0[$];
  bit   q1[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: Y = min(count * 2^W / 2^floor(log2 L), 2^W - 1).
  function automatic exp_t model(input int len, input int c0, input int c1, input bit ovf);
    exp_t e;
    int   k;
    int   v;
    int   c[2];
    c[0] = c0;
    c[1] = c1;
    k = 0;
    while (len > 0 && (1 << (k + 1)) <= len) k++;
    e.k   = k[LW-1:0];
    e.err = (len == 0) || ((len & (len - 1)) != 0) || ovf;
    e.ys  = '0;
    for (int i = 0; i < N; i++) begin
      v = (len == 0) ? 0 : (c[i] * (1 << W)) / (1 << k);
      if (v > (1 << W) - 1) v = (1 << W) - 1;
      e.ys[i*W +: W] = v[W-1:0];
    end
    return e;
  endfunction

  function automatic void fill_directed(input int n, input int o0, input int o1);
    q0.delete();
    q1.delete();
    for (int j = 0; j < n; j++) begin
      q0.push_back(j < o0);
      q1.push_back(j < o1);
    end
  endfunction

  function automatic void fill_random(input int n, input int p0, input int p1);
    q0.delete();
    q1.delete();
    for (int j = 0; j < n; j++) begin
      q0.push_back($urandom_range(99) < p0);
      q1.push_back($urandom_range(99) < p1);
    end
  endfunction

  // Start pulse (optionally colliding with a valid bit and src_done), then n bits from q0/q1.
  task automatic drive_stream(input int n, input bit collide, input int gap_pct);
    int len = 0;
    int c0  = 0;
    int c1  = 0;
    bit ovf = 1'b0;
    start = 1'b1;
    if (collide) begin
      xs_valid = 1'b1;
      xs       = 2'b11;
      src_done = 1'b1;
    end
    @(posedge clk); #1;
    start    = 1'b0;
    xs_valid = 1'b0;
    src_done = 1'b0;
    check("start_out_valid", out_valid, 0);
    check("start_busy", busy, 1);
    if (n == 0) begin
      src_done = 1'b1;
      exp_q.push_back(model(0, 0, 0, 1'b0));
      @(posedge clk); #1;
    end else begin
      for (int j = 0; j < n; j++) begin
        while ($urandom_range(99) < gap_pct) begin
          xs_valid = 1'b0;
          xs       = N'($urandom);
          @(posedge clk); #1;
        end
        xs_valid = 1'b1;
        xs       = {q1[j], q0[j]};
        src_done = (j == n - 1);
        if (len < LMAX) begin
          len++;
          c0 += int'(q0[j]);
          c1 += int'(q1[j]);
`ifdef SC_ET_ACC_PROGRESSIVE_EN
          if (len >= (1 << W) && (len & (len - 1)) == 0) prog_q.push_back(model(len, c0, c1, 0));
`endif
        end else begin
          ovf = 1'b1;
        end
        if (j == n - 1) exp_q.push_back(model(len, c0, c1, ovf));
        @(posedge clk); #1;
      end
    end
    xs_valid = 1'b0;
    src_done = 1'b0;
    check("latency_out_valid", out_valid, 1);
    check("out_busy", busy, 0);
  endtask

  task automatic accept(input int hold);
    repeat (hold) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("accept_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  // Monitor: a result is popped when out_valid rises and must then hold while valid.
  exp_t held;
  bit   prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got Ys=%0h, expected no result", ys);
        end else begin
          held = exp_q.pop_front();
          check("ys", ys, held.ys);
          check("len_log2", len_log2, held.k);
          check("len_err", len_err, held.err);
        end
      end else if (out_valid) begin
        check("hold_ys", ys, held.ys);
        check("hold_len_log2", len_log2, held.k);
        check("hold_len_err", len_err, held.err);
      end
      prev_valid = out_valid;
`ifdef SC_ET_ACC_PROGRESSIVE_EN
      if (prog_valid) begin
        if (prog_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_prog: got Ys=%0h, expected no pulse", ys);
        end else begin
          check("prog_ys", ys, prog_q.pop_front().ys);
        end
      end
`endif
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    xs_valid  = 1'b0;
    xs        = '0;
    src_done  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ys", ys, 0);
    check("rst_len_log2", len_log2, 0);
    check("rst_len_err", len_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Inputs ignored in IDLE.
    xs_valid = 1'b1;
    src_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    xs_valid = 1'b0;
    src_done = 1'b0;
    check("idle_ignore_valid", out_valid, 0);
    check("idle_ignore_busy", busy, 0);

    // 8 bits: 6 and 4 ones.
    fill_directed(8, 6, 4);
    drive_stream(8, 1'b0, 0);
    check("t1_ys", ys, 8'h8C);
    check("t1_len_log2", len_log2, 3);
    check("t1_len_err", len_err, 0);
    accept(3);

    // 256 bits: 208 and 144 ones.
    fill_directed(256, 208, 144);
    drive_stream(256, 1'b0, 20);
    check("t2_ys", ys, 8'h9D);
    check("t2_len_log2", len_log2, 8);
    accept(1);

    // Saturation.
    fill_directed(16, 16, 0);
    drive_stream(16, 1'b0, 0);
    check("t3_ys", ys, 8'h0F);
    accept(0);

    // Non-power-of-two length and zero length.
    fill_directed(6, 3, 2);
    drive_stream(6, 1'b0, 0);
    check("t4_len_err", len_err, 1);
    check("t4_len_log2", len_log2, 2);
    accept(0);
    drive_stream(0, 1'b0, 0);
    check("t4_zero_ys", ys, 0);
    check("t4_zero_err", len_err, 1);
    accept(0);

    // Restart mid-ACCUM after 5 bits; the restart cycle also carries a bit and src_done.
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    xs_valid = 1'b1;
    xs       = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    xs_valid = 1'b0;
    fill_directed(8, 5, 3);
    drive_stream(8, 1'b1, 0);
    check("t5_ys", ys, 8'h6A);
    // Left pending: the next start discards it.

    // Overflow: 260 bits.
    fill_random(260, 50, 30);
    drive_stream(260, 1'b0, 0);
    check("ovf_len_err", len_err, 1);
    check("ovf_len_log2", len_log2, 8);
    accept(2);

    // Reset mid-ACCUM.
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    xs_valid = 1'b1;
    xs       = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ys", ys, 0);
    check("mid_rst_len_log2", len_log2, 0);
    check("mid_rst_len_err", len_err, 0);
    check("mid_rst_busy", busy, 0);
    src_done = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    xs_valid = 1'b0;
    src_done = 1'b0;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);

    // Randomised runs.
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(1) == 0) n = 1 << $urandom_range(8);
      else n = int'($urandom_range(40));
      fill_random(n, int'($urandom_range(100)), int'($urandom_range(100)));
      drive_stream(n, bit'($urandom_range(1)), 25);
      if (r == 15 || $urandom_range(3) != 0) accept(int'($urandom_range(3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef SC_ET_ACC_PROGRESSIVE_EN
    check("prog_scoreboard_empty", prog_q.size(), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
